// File: rtl/adpcm_pkg.sv
// -----------------------------------------------------------------------------
// adpcm_pkg
// Shared definitions for the ADPCM playback controller:
//   - ADDR_W        : width of the sample fetch address (16-bit window, wraps)
//   - SEL_START/END/VOL : cpu_sel register codes (code 3 is ignored)
//   - fetch_state_t : states of the ROM request FSM in adpcm_fetch
// -----------------------------------------------------------------------------
package adpcm_pkg;

    localparam int ADDR_W = 16;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_END   = 2'd1;
    localparam logic [1:0] SEL_VOL   = 2'd2;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/adpcm_fetch.sv
// -----------------------------------------------------------------------------
// adpcm_fetch
// ROM request FSM for the ADPCM controller. Issues one byte fetch at a time
// whenever playback needs a new byte, and discards the data of a transaction
// that was overtaken by a restart.
//
// ROM handshake:
//   rom_req is high for the whole of REQ and rom_addr (from req_addr) does not
//   change while it is high. rom_ack accepts the request; rom_valid marks the
//   single cycle in which rom_data carries the byte. rom_valid may come in the
//   same cycle as rom_ack or any later cycle; it is only looked at in REQ
//   (together with rom_ack) and in WAIT, so a stray rom_valid in IDLE is inert.
//
// Ports:
//   clk_sys, core_reset : clock, asynchronous active-high reset
//   playing, buf_full   : playback active / sample buffer holds a byte
//   stop_fetch          : end address reached (only meaningful in IDLE)
//   restart             : start write this cycle
//   fetch_addr          : next byte address to fetch
//   rom_ack, rom_valid  : ROM handshake inputs
//   rom_req             : fetch request
//   req_addr            : address latched for the outstanding request
//   take                : rom_data must be stored into the buffer this cycle
//   state               : current FSM state (debug / checker visibility)
// -----------------------------------------------------------------------------
module adpcm_fetch
    import adpcm_pkg::*;
(
    input  logic              clk_sys,
    input  logic              core_reset,
    input  logic              playing,
    input  logic              buf_full,
    input  logic              stop_fetch,
    input  logic              restart,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              rom_ack,
    input  logic              rom_valid,
    output logic              rom_req,
    output logic [ADDR_W-1:0] req_addr,
    output logic              take,
    output fetch_state_t      state
);

    fetch_state_t state_next;
    logic         done;
    logic         drop;

    always_ff @(posedge clk_sys or posedge core_reset) begin
        if (core_reset) begin
            state    <= FETCH_IDLE;
            drop     <= 1'b0;
            req_addr <= '0;
        end else begin
            state <= state_next;
            // Latch the address on entry to REQ so a restart during the
            // request cannot disturb rom_addr.
            if (state == FETCH_IDLE && state_next == FETCH_REQ) begin
                req_addr <= fetch_addr;
            end
            if (done) begin
                drop <= 1'b0;
            end else if (restart && state != FETCH_IDLE) begin
                drop <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        rom_req    = 1'b0;
        done       = 1'b0;
        case (state)
            FETCH_IDLE: begin
                // A start write holds off the decision for one cycle so that
                // the new address and the end check are seen together.
                if (playing && !buf_full && !stop_fetch && !restart) begin
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    if (rom_valid) begin
                        done       = 1'b1;
                        state_next = FETCH_IDLE;
                    end else begin
                        state_next = FETCH_WAIT;
                    end
                end
            end
            FETCH_WAIT: begin
                if (rom_valid) begin
                    done       = 1'b1;
                    state_next = FETCH_IDLE;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    // Data belonging to a transaction that was restarted (either earlier, via
    // drop, or in this very cycle) is thrown away.
    assign take = done && !drop && !restart;

endmodule

// File: rtl/adpcm_ctrl.sv
// -----------------------------------------------------------------------------
// adpcm_ctrl
// ADPCM sample playback controller feeding an MSM5205-style decoder. The sound
// CPU programs a start page, an end page and a volume; the controller fetches
// sample bytes from ROM one at a time into a single-byte buffer and hands the
// nibbles (high first) to the decoder on each vclk_cen strobe.
//
// Parameters:
//   ROM_BASE  : byte offset of the sample region in ROM space
//   END_CHECK : 1 = stop when the fetch page reaches end_reg, 0 = never stop
//
// Ports:
//   clk_sys, core_reset   : clock, asynchronous active-high reset
//   vclk_cen              : one-cycle decoder sample strobe
//   cpu_wr/cpu_sel/cpu_data : register writes (0 start, 1 end, 2 volume)
//   rom_addr/rom_req      : fetch address and request
//   rom_ack/rom_valid/rom_data : ROM handshake and returned byte
//   nibble/nibble_stb     : registered ADPCM code and its update strobe
//   msm_reset             : decoder reset, high whenever not playing
//   volume                : latched volume
//   playing               : playback active
//   underrun              : sticky, a strobe arrived with no data buffered
// -----------------------------------------------------------------------------
module adpcm_ctrl
    import adpcm_pkg::*;
#(
    parameter logic [22:0] ROM_BASE  = 23'h000000,
    parameter int          END_CHECK = 1
) (
    input  logic        clk_sys,
    input  logic        core_reset,
    input  logic        vclk_cen,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_sel,
    input  logic [7:0]  cpu_data,
    output logic [22:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic        rom_valid,
    input  logic [7:0]  rom_data,
    output logic [3:0]  nibble,
    output logic        nibble_stb,
    output logic        msm_reset,
    output logic [3:0]  volume,
    output logic        playing,
    output logic        underrun
);

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        end_reg;
    logic [7:0]        buf_byte;
    logic              buf_full;
    logic              phase_high;
    logic              restart;
    logic              stop_fetch;
    logic              take;
    fetch_state_t      fetch_state;

    assign restart    = cpu_wr && (cpu_sel == SEL_START);
    assign stop_fetch = (END_CHECK != 0) && (fetch_addr[15:8] == end_reg);
    assign rom_addr   = ROM_BASE + 23'(req_addr);
    assign msm_reset  = !playing;

    adpcm_fetch u_fetch (
        .clk_sys    (clk_sys),
        .core_reset (core_reset),
        .playing    (playing),
        .buf_full   (buf_full),
        .stop_fetch (stop_fetch),
        .restart    (restart),
        .fetch_addr (fetch_addr),
        .rom_ack    (rom_ack),
        .rom_valid  (rom_valid),
        .rom_req    (rom_req),
        .req_addr   (req_addr),
        .take       (take),
        .state      (fetch_state)
    );

    // CPU-programmed registers that do not touch playback.
    always_ff @(posedge clk_sys or posedge core_reset) begin
        if (core_reset) begin
            end_reg <= 8'h00;
            volume  <= 4'h0;
        end else if (cpu_wr) begin
            if (cpu_sel == SEL_END) begin
                end_reg <= cpu_data;
            end
            if (cpu_sel == SEL_VOL) begin
                volume <= cpu_data[3:0];
            end
        end
    end

    // Playback: buffer, nibble phase, nibble output, playing and underrun.
    // A fill (take) only happens while the buffer is empty and a drain only
    // while it is full, so the two never collide on buf_full.
    always_ff @(posedge clk_sys or posedge core_reset) begin
        if (core_reset) begin
            fetch_addr <= '0;
            buf_byte   <= 8'h00;
            buf_full   <= 1'b0;
            phase_high <= 1'b1;
            nibble     <= 4'h0;
            nibble_stb <= 1'b0;
            playing    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            nibble_stb <= 1'b0;
            if (restart) begin
                // Restart wins over a coincident vclk_cen: nothing is emitted.
                fetch_addr <= {cpu_data, 8'h00};
                buf_full   <= 1'b0;
                phase_high <= 1'b1;
                playing    <= 1'b1;
                underrun   <= 1'b0;
            end else begin
                if (take) begin
                    buf_byte   <= rom_data;
                    buf_full   <= 1'b1;
                    fetch_addr <= fetch_addr + 16'd1;
                end
                if (vclk_cen && playing) begin
                    nibble_stb <= 1'b1;
                    if (buf_full) begin
                        nibble     <= phase_high ? buf_byte[7:4] : buf_byte[3:0];
                        phase_high <= !phase_high;
                        if (!phase_high) begin
                            buf_full <= 1'b0;
                        end
                    end else begin
                        // Starved: emit silence, keep the phase so the next
                        // real byte still starts with its high nibble.
                        nibble   <= 4'h0;
                        underrun <= 1'b1;
                    end
                end
                if (stop_fetch && !buf_full && fetch_state == FETCH_IDLE) begin
                    playing <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/adpcm_ctrl.md
ADPCM_CTRL -- requirements
Module: adpcm_ctrl

Interface
REQ-001 SHALL have parameter ROM_BASE, default 23'h000000: byte offset of the ADPCM sample region in ROM space.
REQ-002 SHALL have parameter END_CHECK, default 1: 1 enables end-address stop, 0 plays until restarted.
REQ-003 SHALL have port clk_sys, input, 1: system clock.
REQ-004 SHALL have port core_reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port vclk_cen, input, 1: one-cycle sample strobe (MSM5205 VCK rate).
REQ-006 SHALL have port cpu_wr, input, 1: one-cycle write strobe, already synchronous to clk_sys.
REQ-007 SHALL have port cpu_sel, input, 2: 0 = start, 1 = end, 2 = volume, 3 = ignored.
REQ-008 SHALL have port cpu_data, input, 8: sound CPU write data.
REQ-009 SHALL have port rom_addr, output, 23: ROM_BASE + fetch_addr.
REQ-010 SHALL have port rom_req, output, 1: fetch request.
REQ-011 SHALL have port rom_ack, input, 1: request accepted.
REQ-012 SHALL have port rom_valid, input, 1: rom_data valid, one cycle.
REQ-013 SHALL have port rom_data, input, 8: fetched byte.
REQ-014 SHALL have port nibble, output, 4: ADPCM code to the decoder.
REQ-015 SHALL have port nibble_stb, output, 1: one-cycle strobe when nibble updates.
REQ-016 SHALL have port msm_reset, output, 1: decoder reset, equal to !playing.
REQ-017 SHALL have port volume, output, 4: latched volume.
REQ-018 SHALL have port playing, output, 1: playback active.
REQ-019 SHALL have port underrun, output, 1: sticky underrun flag, cleared by a start write.

Function
REQ-020 Start write SHALL set fetch_addr = {cpu_data, 8'h00}, empty the buffer, set phase = high, set playing = 1, and clear underrun.
REQ-021 End write SHALL load end_reg = cpu_data. Volume write SHALL load volume = cpu_data[3:0]. Neither write SHALL affect playback state.
REQ-022 The fetch FSM SHALL use states IDLE, REQ and WAIT.
REQ-023 IDLE->REQ SHALL occur when playing, buffer empty and not stop_fetch. rom_req SHALL be 1 only in REQ, and rom_addr SHALL be stable throughout REQ.
REQ-024 REQ->WAIT SHALL occur on rom_ack. rom_valid received in the same cycle as rom_ack SHALL be honoured.
REQ-025 WAIT->IDLE SHALL occur on rom_valid: store the byte, set buffer full, fetch_addr += 1 (16-bit wrap FFFF->0000).
REQ-026 stop_fetch SHALL be (END_CHECK && fetch_addr[15:8] == end_reg), evaluated in IDLE only.
REQ-027 On vclk_cen while playing and buffer full: phase high SHALL emit byte[7:4]; phase low SHALL emit byte[3:0] and empty the buffer. The phase SHALL toggle. nibble_stb SHALL pulse in the same cycle, and nibble SHALL be registered (latency 1 cycle after vclk_cen).
REQ-028 On vclk_cen while playing and buffer empty: emit 4'h0 with nibble_stb, set underrun, and leave the phase unchanged.
REQ-029 playing SHALL clear when stop_fetch is true, the buffer is empty and the FSM is IDLE. nibble SHALL hold its last value.
REQ-030 A start write during REQ/WAIT SHALL be a restart: the outstanding transaction SHALL complete handshake-wise, its data SHALL be discarded (drop flag), and only then SHALL the new address be fetched.
REQ-031 A start write coinciding with vclk_cen SHALL take priority: no nibble, no strobe that cycle.
REQ-032 A start write with cpu_data == end_reg SHALL produce playing = 1 for exactly one IDLE evaluation, then stop with zero nibbles emitted.

Reset
REQ-033 core_reset SHALL force: FSM IDLE, fetch_addr 0, end_reg 0, volume 0, buffer empty, drop 0, phase high, nibble 0, nibble_stb 0, rom_req 0, playing 0, msm_reset 1, underrun 0.
REQ-034 Reset assertion during REQ/WAIT SHALL abandon the transaction. A rom_valid arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-035 Package adpcm_pkg SHALL hold the fetch-state enum, the cpu_sel codes (SEL_START/SEL_END/SEL_VOL) and the ADDR_W = 16 constant.
REQ-036 Sub-module adpcm_fetch SHALL implement the request FSM and drop flag; buffer, phase and nibble logic SHALL stay in adpcm_ctrl.

Verification
REQ-037 Test end write 8'h12, start write 8'h10, ROM bytes A5,3C,..., ack/valid latency 3 cycles: nibbles A,5,3,C,...; exactly 512 bytes fetched (1000-11FF); 1024 strobes; then playing=0 and msm_reset=1.
REQ-038 Test ROM valid delayed 40 cycles with vclk_cen every 8 cycles: underrun=1, 4'h0 nibbles emitted, phase preserved, and the first real nibble is the high nibble.
REQ-039 Test start write 8'h20 while in WAIT for 8'h10xx data: the 10xx byte is discarded and the next rom_addr = ROM_BASE+2000.
REQ-040 Test end_reg 8'h00, start 8'hFF: fetch addresses FF00..FFFF, wrap to 0000, stop; 256 bytes.
REQ-041 Test start write coincident with vclk_cen: no nibble_stb that cycle; fetch_addr=start.
REQ-042 Test core_reset asserted mid-REQ: all outputs take their reset values asynchronously, and a stray rom_valid after release is ignored.
